// File: rtl/mem_arbiter_rr.sv
// Purpose: NUM_PORTS-client round-robin arbiter that feeds cacheline requests into the single cacheline adaptor port.
// Latency: a request seen in IDLE raises the strobe on the next cycle; port_resp pulses one cycle after mem_resp; at least 3 cycles per transaction.
// Backpressure: one transaction in flight at a time; clients hold their request until they see port_resp; the mem-side strobe is held until mem_resp.
// Option: define MEM_ARB_WRITE_PRIO_EN to grant only writers while any writer is pending, so victim writebacks drain before refills.
// Ports:
//   clk, reset_n                      - clock, asynchronous active-low reset
//   port_read/port_write[NUM_PORTS]   - per-client line requests (write wins if both are set)
//   port_address/port_wdata           - packed client address/line, client i at [i*W +: W]
//   port_rdata                        - last read line, broadcast to all clients
//   port_resp[NUM_PORTS]              - one-hot completion pulse
//   mem_read/mem_write/mem_address/mem_wdata - registered request to the adaptor
//   mem_rdata/mem_resp                - adaptor read line and completion
module mem_arbiter_rr #(
   parameter int NUM_PORTS = 2,
   parameter int LINE_W    = 256,
   parameter int ADDR_W    = 32
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic [NUM_PORTS-1:0]          port_read,
   input  logic [NUM_PORTS-1:0]          port_write,
   input  logic [NUM_PORTS*ADDR_W-1:0]   port_address,
   input  logic [NUM_PORTS*LINE_W-1:0]   port_wdata,
   output logic [LINE_W-1:0]             port_rdata,
   output logic [NUM_PORTS-1:0]          port_resp,
   output logic                          mem_read,
   output logic                          mem_write,
   output logic [ADDR_W-1:0]             mem_address,
   output logic [LINE_W-1:0]             mem_wdata,
   input  logic [LINE_W-1:0]             mem_rdata,
   input  logic                          mem_resp
);

   localparam int GRANT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam logic [GRANT_W-1:0] LAST_PORT = GRANT_W'(NUM_PORTS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [GRANT_W-1:0]   grant;
   logic [GRANT_W-1:0]   last_grant;

   logic [NUM_PORTS-1:0] req;
   logic [NUM_PORTS-1:0] elig;

   logic                 found_hi, found_lo;
   logic [GRANT_W-1:0]   idx_hi, idx_lo;
   logic                 win_found;
   logic [GRANT_W-1:0]   win_idx;
   logic [ADDR_W-1:0]    win_addr;
   logic [LINE_W-1:0]    win_wdata;
   logic                 win_write;

   logic                 take_req;
   logic                 take_resp;

   // Eligibility: every requester, or only writers when write priority is built in.
   always_comb begin
      req = port_read | port_write;
`ifdef MEM_ARB_WRITE_PRIO_EN
      elig = (|port_write) ? port_write : req;
`else
      elig = req;
`endif
   end

   // Round-robin pick without a modulo: the lowest eligible index above
   // last_grant wins; if there is none, wrap to the lowest eligible index overall.
   // The loop runs downward so the last hit is the lowest index.
   always_comb begin
      found_hi = 1'b0;
      found_lo = 1'b0;
      idx_hi   = '0;
      idx_lo   = '0;
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
         if (elig[i]) begin
            found_lo = 1'b1;
            idx_lo   = GRANT_W'(i);
            if (i > int'(last_grant)) begin
               found_hi = 1'b1;
               idx_hi   = GRANT_W'(i);
            end
         end
      end
      win_found = found_lo;
      win_idx   = found_hi ? idx_hi : idx_lo;
   end

   // Mux the winner's request fields.
   always_comb begin
      win_addr  = '0;
      win_wdata = '0;
      win_write = 1'b0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (GRANT_W'(i) == win_idx) begin
            win_addr  = port_address[i*ADDR_W +: ADDR_W];
            win_wdata = port_wdata[i*LINE_W +: LINE_W];
            win_write = port_write[i];
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM next-state logic and load enables.
   always_comb begin
      state_nxt = state;
      take_req  = 1'b0;
      take_resp = 1'b0;
      case (state)
         IDLE: begin
            if (win_found) begin
               state_nxt = ISSUE;
               take_req  = 1'b1;
            end
         end
         ISSUE: begin
            if (mem_resp) begin
               state_nxt = DONE;
               take_resp = 1'b1;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Registered datapath and strobes. The latched op lives in mem_write/mem_read,
   // which only change on request capture and on mem_resp.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         grant       <= '0;
         last_grant  <= LAST_PORT;
         mem_read    <= 1'b0;
         mem_write   <= 1'b0;
         mem_address <= '0;
         mem_wdata   <= '0;
         port_rdata  <= '0;
         port_resp   <= '0;
      end else begin
         port_resp <= '0;
         if (take_req) begin
            grant       <= win_idx;
            mem_address <= win_addr;
            mem_wdata   <= win_wdata;
            mem_write   <= win_write;
            mem_read    <= ~win_write;
         end
         if (take_resp) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            // Write completions leave the last read line in place.
            if (!mem_write) begin
               port_rdata <= mem_rdata;
            end
            port_resp <= NUM_PORTS'(1) << grant;
         end
         if (state == DONE) begin
            last_grant <= grant;
         end
      end
   end

endmodule
